modulo_updown_counter: RTL and testbench

MODULO_UPDOWN_COUNTER -- requirements
Module: modulo_updown_counter

---
 rtl/counter_pkg.sv | 14 +
 rtl/count_next_calc.sv | 57 +++++
 rtl/modulo_updown_counter.sv | 92 +++++++++
 tb/tb_modulo_updown_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo up/down counter.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bound behaviour; the unused encoding 2'b11 behaves like SAT.
    typedef enum logic [1:0] {
        WRAP     = 2'b00,
        SAT      = 2'b01,
        ONESHOT  = 2'b10,
        SAT_ALT  = 2'b11
    } mode_t;

endpackage

// File: rtl/count_next_calc.sv
// Combinational next-count and bound-event calculator for one enabled step.
module count_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic             i_up,
    input  mode_t            i_mode,
    output logic [WIDTH-1:0] o_next_c,
    output logic             o_wrap_c,
    output logic             o_ovf_c,
    output logic             o_unf_c,
    output logic             o_done_c
);

    // Interior steps move by one; bound steps wrap, saturate or terminate.
    always_comb begin
        o_next_c = i_count;
        o_wrap_c = 1'b0;
        o_ovf_c  = 1'b0;
        o_unf_c  = 1'b0;
        o_done_c = 1'b0;
        if (i_up) begin
            // ">=" also covers a max_val lowered below the current count
            if (i_count < i_max_val) begin
                o_next_c = i_count + WIDTH'(1);
            end else begin
                o_ovf_c = 1'b1;
                case (i_mode)
                    WRAP: begin
                        o_next_c = '0;
                        o_wrap_c = 1'b1;
                    end
                    ONESHOT: o_done_c = 1'b1;
                    default: ;
                endcase
            end
        end else begin
            if (i_count != '0) begin
                o_next_c = i_count - WIDTH'(1);
            end else begin
                o_unf_c = 1'b1;
                case (i_mode)
                    WRAP: begin
                        o_next_c = i_max_val;
                        o_wrap_c = 1'b1;
                    end
                    ONESHOT: o_done_c = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/modulo_updown_counter.sv
// Programmable-bound up/down counter with wrap, saturate and one-shot modes.
module modulo_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] max_val,
    input  mode_t            mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap_pulse,
    output logic             ovf,
    output logic             unf,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_unf;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrap;
    logic             w_ovf;
    logic             w_unf;
    logic             w_done;
    logic             w_step;

    count_next_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_count   (r_count),
        .i_max_val (max_val),
        .i_up      (up_down),
        .i_mode    (mode),
        .o_next_c  (w_next),
        .o_wrap_c  (w_wrap),
        .o_ovf_c   (w_ovf),
        .o_unf_c   (w_unf),
        .o_done_c  (w_done)
    );

    // Load beats a step; a finished one-shot ignores enable.
    assign w_step     = enable & ~load & ~r_done;
    assign w_load_val = (d_in > max_val) ? max_val : d_in;

    // Counter, pulse, sticky flags and terminal state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= RESET_VAL;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (load) begin
                r_count <= w_load_val;
                r_wrap  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_step) begin
                r_count <= w_next;
                r_wrap  <= w_wrap;
                r_done  <= w_done;
            end else begin
                r_wrap  <= 1'b0;
            end
            // a set in the same cycle wins over clr_flags
            r_ovf <= (w_step & w_ovf) | (r_ovf & ~clr_flags);
            r_unf <= (w_step & w_unf) | (r_unf & ~clr_flags);
        end
    end

    assign count      = r_count;
    assign wrap_pulse = r_wrap;
    assign ovf        = r_ovf;
    assign unf        = r_unf;
    assign done       = r_done;
    assign at_max     = (r_count >= max_val);
    assign at_zero    = (r_count == '0);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Directed scenarios plus random stimulus against an arithmetic reference model.
module tb_modulo_updown_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [7:0] d_in;
    logic [7:0] max_val;
    mode_t      mode;
    logic       clr_flags;
    logic [7:0] count;
    logic       at_max;
    logic       at_zero;
    logic       wrap_pulse;
    logic       ovf;
    logic       unf;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int m_cnt  = 0;
    bit m_wrap = 0;
    bit m_ovf  = 0;
    bit m_unf  = 0;
    bit m_done = 0;

    modulo_updown_counter #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .d_in       (d_in),
        .max_val    (max_val),
        .mode       (mode),
        .clr_flags  (clr_flags),
        .count      (count),
        .at_max     (at_max),
        .at_zero    (at_zero),
        .wrap_pulse (wrap_pulse),
        .ovf        (ovf),
        .unf        (unf),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Next state from the behavioural rules, using the inputs held for this edge.
    task automatic model_update();
        int  mx;
        int  md;
        bit  set_o;
        bit  set_u;
        mx    = int'(max_val);
        md    = int'(mode);
        set_o = 0;
        set_u = 0;
        if (!rst_n) begin
            m_cnt = 0; m_wrap = 0; m_ovf = 0; m_unf = 0; m_done = 0;
            return;
        end
        if (load) begin
            m_cnt  = (int'(d_in) < mx) ? int'(d_in) : mx;
            m_done = 0;
            m_wrap = 0;
        end else if (enable && !m_done) begin
            m_wrap = 0;
            if (up_down) begin
                if (m_cnt < mx) m_cnt = m_cnt + 1;
                else begin
                    set_o = 1;
                    if (md == 0) begin m_cnt = 0; m_wrap = 1; end
                    else if (md == 2) m_done = 1;
                end
            end else begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    set_u = 1;
                    if (md == 0) begin m_cnt = mx; m_wrap = 1; end
                    else if (md == 2) m_done = 1;
                end
            end
        end else begin
            m_wrap = 0;
        end
        m_ovf = set_o || (m_ovf && !clr_flags);
        m_unf = set_u || (m_unf && !clr_flags);
    endtask

    task automatic check_all();
        check("count",      32'(count),      32'(m_cnt));
        check("at_max",     32'(at_max),     32'(m_cnt >= int'(max_val)));
        check("at_zero",    32'(at_zero),    32'(m_cnt == 0));
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        check("ovf",        32'(ovf),        32'(m_ovf));
        check("unf",        32'(unf),        32'(m_unf));
        check("done",       32'(done),       32'(m_done));
    endtask

    task automatic step_cycle();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        d_in = 8'h00; max_val = 8'hFF; mode = WRAP; clr_flags = 1'b0;
        step_cycle();
        step_cycle();
        check("rst_count", 32'(count), 32'h00);
        rst_n = 1'b1;

        // load and count up/down
        load = 1'b1; d_in = 8'h07;
        step_cycle();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        repeat (4) step_cycle();
        check("s40_up", 32'(count), 32'h0B);
        up_down = 1'b0;
        repeat (3) step_cycle();
        check("s40_down", 32'(count), 32'h08);

        // WRAP at max_val
        enable = 1'b0; max_val = 8'h09; mode = WRAP; load = 1'b1; d_in = 8'h08;
        step_cycle();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        step_cycle();
        check("s41_c0", 32'(count), 32'h09);
        check("s41_w0", 32'(wrap_pulse), 32'h0);
        step_cycle();
        check("s41_c1", 32'(count), 32'h00);
        check("s41_w1", 32'(wrap_pulse), 32'h1);
        step_cycle();
        check("s41_c2", 32'(count), 32'h01);
        check("s41_w2", 32'(wrap_pulse), 32'h0);
        check("s41_ovf", 32'(ovf), 32'h1);
        enable = 1'b0; clr_flags = 1'b1;
        step_cycle();
        check("s41_clr", 32'(ovf), 32'h0);
        clr_flags = 1'b0;

        // SAT at zero
        mode = SAT; load = 1'b1; d_in = 8'h01;
        step_cycle();
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        repeat (3) begin
            step_cycle();
            check("s42_c", 32'(count), 32'h00);
            check("s42_w", 32'(wrap_pulse), 32'h0);
        end
        check("s42_unf", 32'(unf), 32'h1);
        clr_flags = 1'b1;
        step_cycle();
        check("s42_set_wins", 32'(unf), 32'h1);
        clr_flags = 1'b0;

        // ONESHOT terminal
        enable = 1'b0; mode = ONESHOT; max_val = 8'h03; load = 1'b1; d_in = 8'h02;
        step_cycle();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        repeat (3) step_cycle();
        check("s43_c", 32'(count), 32'h03);
        check("s43_done", 32'(done), 32'h1);
        enable = 1'b0; load = 1'b1; d_in = 8'h01;
        step_cycle();
        check("s43_reload_c", 32'(count), 32'h01);
        check("s43_reload_d", 32'(done), 32'h0);
        load = 1'b0;

        // reset mid-count, and no change between edges
        mode = WRAP; max_val = 8'hFF; load = 1'b1; d_in = 8'h03;
        step_cycle();
        load = 1'b0; enable = 1'b1; up_down = 1'b1;
        repeat (2) step_cycle();
        check("s44_pre", 32'(count), 32'h05);
        rst_n = 1'b0;
        #2;
        check("s44_sync", 32'(count), 32'(m_cnt));
        load = 1'b1; d_in = 8'hAA; clr_flags = 1'b1;
        step_cycle();
        check("s44_c", 32'(count), 32'h00);
        rst_n = 1'b1; clr_flags = 1'b0;

        // load clamping, then lowered bound in WRAP
        max_val = 8'h0A; load = 1'b1; d_in = 8'h0C; enable = 1'b1; up_down = 1'b1;
        step_cycle();
        check("s45_clamp", 32'(count), 32'h0A);
        load = 1'b0; max_val = 8'h04;
        step_cycle();
        check("s45_c", 32'(count), 32'h00);
        check("s45_w", 32'(wrap_pulse), 32'h1);

        // random traffic, small bounds so every mode reaches its limits
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            load      = ($urandom_range(0, 7) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            up_down   = 1'($urandom_range(0, 1));
            clr_flags = ($urandom_range(0, 7) == 0);
            d_in      = 8'($urandom_range(0, 255));
            mode      = mode_t'(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0)
                max_val = 8'($urandom_range(0, 1) == 0 ? $urandom_range(0, 12) : $urandom_range(0, 255));
            step_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
